// File: rtl/lot_pkg.sv
// Shared types and constants for the parking-lot gate controller.
// Lane states are always declared; R states are only reachable with WRONG_WAY_EN.
package lot_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_F1   = 3'd1,
        S_F2   = 3'd2,
        S_F3   = 3'd3,
        S_ERR  = 3'd4,
        S_R1   = 3'd5,
        S_R2   = 3'd6,
        S_R3   = 3'd7
    } lane_state_t;

    localparam int LOT_MAX_CAPACITY = 16;
    localparam int LOT_COUNT_W      = 5;

    typedef logic [1:0] sense_t;

    localparam sense_t SENSE_NONE  = 2'b00;
    localparam sense_t SENSE_A     = 2'b10;
    localparam sense_t SENSE_AB    = 2'b11;
    localparam sense_t SENSE_B     = 2'b01;

endpackage

// File: rtl/lot_gate_controller_lane_fsm.sv
// Per-lane photosensor pair decoder; fwd/rev are combinational completion flags.
// Reverse traversal tracking (R1..R3) is built only when WRONG_WAY_EN is defined.
module lane_fsm
    import lot_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    output logic fwd,
    output logic rev
);

    lane_state_t r_state;
    lane_state_t w_next;
    sense_t      w_ab;

    assign w_ab = {a, b};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        fwd    = 1'b0;
        rev    = 1'b0;
        case (r_state)
            S_IDLE: begin
                case (w_ab)
                    SENSE_A:    w_next = S_F1;
                    SENSE_NONE: w_next = S_IDLE;
`ifdef WRONG_WAY_EN
                    SENSE_B:    w_next = S_R1;
`endif
                    default:    w_next = S_ERR;
                endcase
            end
            S_F1: begin
                case (w_ab)
                    SENSE_A:    w_next = S_F1;
                    SENSE_AB:   w_next = S_F2;
                    SENSE_NONE: w_next = S_IDLE;
                    default:    w_next = S_ERR;
                endcase
            end
            S_F2: begin
                case (w_ab)
                    SENSE_AB:   w_next = S_F2;
                    SENSE_B:    w_next = S_F3;
                    SENSE_A:    w_next = S_F1;
                    default:    w_next = S_ERR;
                endcase
            end
            S_F3: begin
                case (w_ab)
                    SENSE_B:    w_next = S_F3;
                    SENSE_NONE: begin
                        w_next = S_IDLE;
                        fwd    = 1'b1;
                    end
                    SENSE_AB:   w_next = S_F2;
                    default:    w_next = S_ERR;
                endcase
            end
            S_ERR: begin
                // Only a fully clear lane re-arms the decoder.
                if (w_ab == SENSE_NONE) begin
                    w_next = S_IDLE;
                end
            end
`ifdef WRONG_WAY_EN
            S_R1: begin
                case (w_ab)
                    SENSE_B:    w_next = S_R1;
                    SENSE_AB:   w_next = S_R2;
                    SENSE_NONE: w_next = S_IDLE;
                    default:    w_next = S_ERR;
                endcase
            end
            S_R2: begin
                case (w_ab)
                    SENSE_AB:   w_next = S_R2;
                    SENSE_A:    w_next = S_R3;
                    SENSE_B:    w_next = S_R1;
                    default:    w_next = S_ERR;
                endcase
            end
            S_R3: begin
                case (w_ab)
                    SENSE_A:    w_next = S_R3;
                    SENSE_NONE: begin
                        w_next = S_IDLE;
                        rev    = 1'b1;
                    end
                    SENSE_AB:   w_next = S_R2;
                    default:    w_next = S_ERR;
                endcase
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: rtl/lot_gate_controller.sv
// Parking-lot gate controller: two lane decoders, event merge, status flags.
// Define WRONG_WAY_EN to count reverse traversals and pulse wrong_way.
module lot_gate_controller
    import lot_pkg::*;
#(
    parameter int CAPACITY = LOT_MAX_CAPACITY
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_a,
    input  logic                   in_b,
    input  logic                   out_a,
    input  logic                   out_b,
    input  logic [LOT_COUNT_W-1:0] count,
    output logic                   incr,
    output logic                   decr,
    output logic                   full,
    output logic                   empty,
    output logic                   entry_open,
    output logic                   wrong_way
);

    localparam logic [LOT_COUNT_W-1:0] CAP_L = LOT_COUNT_W'(CAPACITY);

    logic w_en_fwd;
    logic w_en_rev;
    logic w_ex_fwd;
    logic w_ex_rev;
    logic w_car_in;
    logic w_car_out;
    logic r_incr;
    logic r_decr;

    lane_fsm u_entry (
        .clk   (clk),
        .reset (reset),
        .a     (in_a),
        .b     (in_b),
        .fwd   (w_en_fwd),
        .rev   (w_en_rev)
    );

    lane_fsm u_exit (
        .clk   (clk),
        .reset (reset),
        .a     (out_a),
        .b     (out_b),
        .fwd   (w_ex_fwd),
        .rev   (w_ex_rev)
    );

    // A reverse pass through one lane is equivalent to a forward pass through the other.
    assign w_car_in  = w_en_fwd | w_ex_rev;
    assign w_car_out = w_ex_fwd | w_en_rev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_incr <= 1'b0;
            r_decr <= 1'b0;
        end else begin
            r_incr <= w_car_in & ~w_car_out;
            r_decr <= w_car_out & ~w_car_in;
        end
    end

`ifdef WRONG_WAY_EN
    logic r_wrong_way;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrong_way <= 1'b0;
        end else begin
            r_wrong_way <= w_en_rev | w_ex_rev;
        end
    end

    assign wrong_way = r_wrong_way;
`else
    assign wrong_way = 1'b0;
`endif

    assign incr       = r_incr;
    assign decr       = r_decr;
    assign full       = (count >= CAP_L);
    assign empty      = (count == '0);
    assign entry_open = ~full;

endmodule

// File: tb/tb_lot_gate_controller.sv
// Bench for lot_gate_controller: directed vector table, corner sequences,
// then random sensor traffic against a position-distance lane model.
module tb_lot_gate_controller;

`ifdef WRONG_WAY_EN
    localparam bit WW = 1'b1;
`else
    localparam bit WW = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       in_a, in_b, out_a, out_b;
    logic [4:0] count;
    logic       incr, decr, full, empty, entry_open, wrong_way;
    logic       incr10, decr10, full10, empty10, open10, ww10;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lot_gate_controller dut (
        .clk(clk), .reset(reset),
        .in_a(in_a), .in_b(in_b), .out_a(out_a), .out_b(out_b),
        .count(count),
        .incr(incr), .decr(decr), .full(full), .empty(empty),
        .entry_open(entry_open), .wrong_way(wrong_way)
    );

    lot_gate_controller #(.CAPACITY(10)) dut10 (
        .clk(clk), .reset(reset),
        .in_a(in_a), .in_b(in_b), .out_a(out_a), .out_b(out_b),
        .count(count),
        .incr(incr10), .decr(decr10), .full(full10), .empty(empty10),
        .entry_open(open10), .wrong_way(ww10)
    );

    typedef struct {
        logic       rst;
        logic [1:0] en;
        logic [1:0] ex;
        logic [4:0] cnt;
        logic       incr;
        logic       decr;
        logic       ww;
        logic       full;
        logic       empty;
        logic       open;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string name, input int idx, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0d got=%b want=%b", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [1:0] en, input logic [1:0] ex,
                       input int c, input logic i, input logic d, input logic w);
        vec_t v;
        v.rst   = r;
        v.en    = en;
        v.ex    = ex;
        v.cnt   = 5'(c);
        v.incr  = i;
        v.decr  = d;
        v.ww    = w;
        v.full  = (c >= 16);
        v.empty = (c == 0);
        v.open  = (c < 16);
        tv.push_back(v);
    endtask

    task automatic drive(input logic r, input logic [1:0] en, input logic [1:0] ex, input logic [4:0] c);
        reset = r;
        {in_a, in_b}   = en;
        {out_a, out_b} = ex;
        count = c;
    endtask

    // Lane model: mode 0 idle, 1 forward, 2 reverse, 3 error.
    // Each non-clear pattern has a position along the path; a legal step moves at most one place.
    function automatic int fpos(input logic [1:0] p);
        case (p)
            2'b10:   return 1;
            2'b11:   return 2;
            2'b01:   return 3;
            default: return 0;
        endcase
    endfunction

    function automatic int rpos(input logic [1:0] p);
        case (p)
            2'b01:   return 1;
            2'b11:   return 2;
            2'b10:   return 3;
            default: return 0;
        endcase
    endfunction

    task automatic lane_model(input int mi, input int pi, input logic [1:0] p,
                              output int mo, output int po, output bit f, output bit rv);
        int q;
        mo = mi;
        po = pi;
        f  = 1'b0;
        rv = 1'b0;
        case (mi)
            0: begin
                if (p == 2'b10) begin
                    mo = 1; po = 1;
                end else if (p == 2'b01 && WW) begin
                    mo = 2; po = 1;
                end else if (p != 2'b00) begin
                    mo = 3;
                end
            end
            1, 2: begin
                if (p == 2'b00) begin
                    if (pi == 1) begin
                        mo = 0;
                    end else if (pi == 3) begin
                        mo = 0;
                        if (mi == 1) f = 1'b1;
                        else rv = 1'b1;
                    end else begin
                        mo = 3;
                    end
                end else begin
                    q = (mi == 1) ? fpos(p) : rpos(p);
                    if (q - pi <= 1 && pi - q <= 1) po = q;
                    else mo = 3;
                end
            end
            default: if (p == 2'b00) mo = 0;
        endcase
    endtask

    function automatic logic [1:0] nextpat(input logic [1:0] cur, input int r);
        logic [1:0] n;
        n = cur;
        if (r < 50) begin
            n = cur;
        end else if (r < 80) begin
            case (cur)
                2'b00: n = 2'b10;
                2'b10: n = 2'b11;
                2'b11: n = 2'b01;
                default: n = 2'b00;
            endcase
        end else if (r < 90) begin
            case (cur)
                2'b00: n = 2'b01;
                2'b01: n = 2'b11;
                2'b11: n = 2'b10;
                default: n = 2'b00;
            endcase
        end else begin
            n = 2'($urandom_range(0, 3));
        end
        return n;
    endfunction

    initial begin
        int em, ep, xm, xp;
        bit ef, er, xf, xr, cin, cout;
        logic ei, ed, ew;
        logic [1:0] pen, pex;
        logic [4:0] c;
        drive(1'b1, 2'b00, 2'b00, 5'd0);

        add(1, 2'b00, 2'b00, 0, 0, 0, 0);
        add(0, 2'b10, 2'b00, 0, 0, 0, 0);
        add(0, 2'b11, 2'b00, 0, 0, 0, 0);
        add(0, 2'b01, 2'b00, 0, 0, 0, 0);
        add(0, 2'b00, 2'b00, 0, 1, 0, 0);
        add(0, 2'b00, 2'b00, 1, 0, 0, 0);
        add(0, 2'b10, 2'b00, 1, 0, 0, 0);
        add(0, 2'b11, 2'b00, 1, 0, 0, 0);
        add(0, 2'b10, 2'b00, 1, 0, 0, 0);
        add(0, 2'b00, 2'b00, 1, 0, 0, 0);
        add(0, 2'b11, 2'b00, 1, 0, 0, 0);
        add(0, 2'b00, 2'b00, 1, 0, 0, 0);
        add(0, 2'b10, 2'b00, 1, 0, 0, 0);
        add(0, 2'b11, 2'b00, 1, 0, 0, 0);
        add(0, 2'b01, 2'b00, 1, 0, 0, 0);
        add(0, 2'b00, 2'b00, 1, 1, 0, 0);
        add(0, 2'b10, 2'b10, 5, 0, 0, 0);
        add(0, 2'b11, 2'b11, 5, 0, 0, 0);
        add(0, 2'b01, 2'b01, 5, 0, 0, 0);
        add(0, 2'b00, 2'b00, 5, 0, 0, 0);
        add(0, 2'b10, 2'b00, 5, 0, 0, 0);
        add(0, 2'b11, 2'b10, 5, 0, 0, 0);
        add(0, 2'b01, 2'b11, 5, 0, 0, 0);
        add(0, 2'b00, 2'b01, 5, 1, 0, 0);
        add(0, 2'b00, 2'b00, 6, 0, 1, 0);
        add(0, 2'b00, 2'b10, 16, 0, 0, 0);
        add(0, 2'b00, 2'b11, 16, 0, 0, 0);
        add(0, 2'b00, 2'b01, 16, 0, 0, 0);
        add(0, 2'b00, 2'b00, 16, 0, 1, 0);
        add(0, 2'b00, 2'b00, 15, 0, 0, 0);
        add(0, 2'b01, 2'b00, 15, 0, 0, 0);
        add(0, 2'b11, 2'b00, 15, 0, 0, 0);
        add(0, 2'b10, 2'b00, 15, 0, 0, 0);
        add(0, 2'b00, 2'b00, 15, 0, WW, WW);
        add(0, 2'b10, 2'b00, 15, 0, 0, 0);
        add(0, 2'b11, 2'b00, 15, 0, 0, 0);
        add(1, 2'b11, 2'b00, 15, 0, 0, 0);
        add(0, 2'b01, 2'b00, 15, 0, 0, 0);
        add(0, 2'b00, 2'b00, 15, 0, 0, 0);
        add(0, 2'b10, 2'b00, 15, 0, 0, 0);
        add(0, 2'b11, 2'b00, 15, 0, 0, 0);
        add(0, 2'b01, 2'b00, 15, 0, 0, 0);
        add(0, 2'b00, 2'b00, 15, 1, 0, 0);
        add(0, 2'b00, 2'b00, 15, 0, 0, 0);

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].rst, tv[i].en, tv[i].ex, tv[i].cnt);
            @(posedge clk);
            #1;
            chk("incr", i, incr, tv[i].incr);
            chk("decr", i, decr, tv[i].decr);
            chk("wrong_way", i, wrong_way, tv[i].ww);
            chk("full", i, full, tv[i].full);
            chk("empty", i, empty, tv[i].empty);
            chk("entry_open", i, entry_open, tv[i].open);
        end

        // Reduced capacity instance: full at exactly CAPACITY.
        count = 5'd10;
        #1;
        chk("cap10_full", 10, full10, 1'b1);
        chk("cap10_open", 10, open10, 1'b0);
        count = 5'd9;
        #1;
        chk("cap10_full", 9, full10, 1'b0);
        chk("cap10_open", 9, open10, 1'b1);

        // Random traffic; model starts from a reset cycle.
        drive(1'b1, 2'b00, 2'b00, 5'd0);
        @(posedge clk);
        #1;
        em = 0; ep = 0; xm = 0; xp = 0;
        pen = 2'b00;
        pex = 2'b00;
        for (int n = 0; n < 3000; n++) begin
            pen = nextpat(pen, int'($urandom_range(0, 99)));
            pex = nextpat(pex, int'($urandom_range(0, 99)));
            c = 5'($urandom_range(0, 16));
            drive(($urandom_range(0, 99) == 0), pen, pex, c);
            @(posedge clk);
            if (reset) begin
                em = 0; ep = 0; xm = 0; xp = 0;
                ei = 1'b0; ed = 1'b0; ew = 1'b0;
            end else begin
                lane_model(em, ep, pen, em, ep, ef, er);
                lane_model(xm, xp, pex, xm, xp, xf, xr);
                cin  = ef | xr;
                cout = xf | er;
                ei = cin & ~cout;
                ed = cout & ~cin;
                ew = er | xr;
            end
            #1;
            chk("rnd_incr", n, incr, ei);
            chk("rnd_decr", n, decr, ed);
            chk("rnd_wrong_way", n, wrong_way, ew);
            chk("rnd_full", n, full, (c >= 16));
            chk("rnd_empty", n, empty, (c == 0));
            chk("rnd_full10", n, full10, (c >= 10));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lot_gate_controller.md
# lot_gate_controller

Sequencing controller for the parking-lot occupancy datapath. It decodes the two photosensor pairs at the entry lane and the exit lane into vehicle-passage events. It merges those events into single-cycle increase/decrease strobes for the car counter, and derives full/empty/gate status from the counter's current count. It sits between the synchronized sensor inputs and the car counter in the lot top level.

## Interface
- CAPACITY, 16, lot capacity in cars; legal range 1..16 (counter saturates at 16)
- clk  input  1  system clock; all state updates on posedge
- reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
- in_a, in_b  input  1 each  entry-lane sensors; a is outer, b is inner; already synchronized to clk
- out_a, out_b  input  1 each  exit-lane sensors; a is inner, b is outer; already synchronized
- count  input  5  current occupancy from the car counter
- incr  output  1  one-cycle strobe: one car added
- decr  output  1  one-cycle strobe: one car removed
- full  output  1  count >= CAPACITY
- empty  output  1  count == 0
- entry_open  output  1  entry gate may open (= ~full)
- wrong_way  output  1  one-cycle strobe: reverse traversal detected (0 when feature compiled out)

## Operation
- Each lane runs an independent FSM, with states IDLE, F1, F2, F3, ERR, plus R1, R2, R3 under WRONG_WAY_EN. Sensor pattern is {a,b}.
- IDLE: 10 → F1; 00 → IDLE; 11 or 01 → ERR (01 → R1 under WRONG_WAY_EN).
- F1: 10 hold; 11 → F2; 00 → IDLE (abort, no event); 01 → ERR.
- F2: 11 hold; 01 → F3; 10 → F1 (back-up); 00 → ERR.
- F3: 01 hold; 00 → IDLE and fwd event; 11 → F2; 10 → ERR.
- ERR: any non-00 holds; 00 → IDLE; no event ever emitted.
- Entry-lane fwd event = car in. Exit-lane fwd event = car out.
- Merge rule, same cycle:
  - car in only → incr.
  - car out only → decr.
  - both → neither (net zero).
  - none → neither.
- incr and decr are never high together.
- Events are issued regardless of full/empty. Counter saturation is the counter's responsibility.
- full, empty and entry_open are combinational from count and CAPACITY.

## Timing
- Sensors are sampled every posedge. Each lane step may last any number of cycles (hold states).
- Completion latency: the completing 00 is sampled at edge N. incr/decr/wrong_way are registered and high during cycle N→N+1, for exactly one cycle. The counter reflects the change after edge N+1.
- Back-to-back cars: a new F1 entry is accepted in the cycle immediately after IDLE is reached. Minimum 4 sampled steps per car.
- Reset values: both lanes IDLE; incr=0, decr=0, wrong_way=0. full/empty/entry_open follow count (empty=1 with count=0).
- Reset mid-sequence: lanes forced to IDLE and no event is emitted. The partial vehicle afterwards follows the normal transitions from IDLE (11 or 01 → ERR, so it is not counted).
- Illegal two-bit jumps are never interpreted as a skipped step.

## Configuration
- WRONG_WAY_EN defined:
  - Reverse path IDLE→R1(01)→R2(11)→R3(10)→IDLE(00) is tracked with the mirrored back-up/abort rules.
  - Completion emits a rev event: entry-lane rev → counts as car out; exit-lane rev → counts as car in. These are merged by the same rule as fwd events.
  - wrong_way pulses in the same cycle as the resulting strobe. If both lanes complete reverse traversals together, wrong_way pulses once.
- Not defined:
  - The R states do not exist; IDLE with 01 → ERR.
  - wrong_way is tied to 0.

## Structure
- Package lot_pkg holds:
  - lane_state_t enum (all states, R states always declared)
  - LOT_MAX_CAPACITY = 16
  - count width constant 5
- Sub-module lane_fsm:
  - inputs clk, reset, a, b
  - outputs fwd, rev (combinational completion flags)
  - instantiated twice
- The top owns the merge logic and output registers.

## Test plan
- Reset with all sensors 00, count=0 → incr=decr=wrong_way=0, empty=1, full=0, entry_open=1.
- Entry lane 00,10,11,01,00 (one per cycle) → incr high exactly one cycle, the cycle after 00 is sampled; with a real counter, count goes 0→1.
- Entry lane 00,10,11,10,00 (back-up) and 00,11,00 (illegal jump) → no incr/decr. Lane returns to IDLE after 00 and then counts the next legal car.
- Both lanes complete forward on the same edge with count=5 → incr=decr=0, count stays 5. Staggered by one cycle → incr then decr, count 5→6→5.
- count=16, CAPACITY=16 → full=1, entry_open=0; exit pass → decr pulse, full deasserts at count=15. CAPACITY=10, count=10 → full=1.
- Reverse 00,01,11,10,00 on the entry lane:
  - with WRONG_WAY_EN → decr and wrong_way pulse together.
  - without → no strobes, wrong_way stays 0.
- Reset asserted during F2 → no strobe, lane IDLE.
